// File: rtl/pin_stamp_if.sv
// rtl/pin_stamp_if.sv - capture strobe and FIFO readout bus for pin_stamp
interface pin_stamp_if #(
  parameter int COARSE_W = 12
);
  logic                str;
  logic                pin_out;
  logic [2:0]          ptime;
  logic                rd_en;
  logic [COARSE_W+4:0] dout;
  logic                empty;
  logic                full;
  logic [7:0]          ovf_cnt;

  modport master (
    output str, pin_out, ptime, rd_en,
    input  dout, empty, full, ovf_cnt
  );

  modport slave (
    input  str, pin_out, ptime, rd_en,
    output dout, empty, full, ovf_cnt
  );
endinterface

// File: rtl/pin_stamp.sv
// rtl/pin_stamp.sv - pin edge time stamper with FWFT FIFO (optional PIN_STAMP_ROLLOVER_EN markers)
module pin_stamp #(
  parameter int COARSE_W = 12,
  parameter int DEPTH    = 16
) (
  input  logic        i_clk300,
  input  logic        i_rst,
  pin_stamp_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = COARSE_W + 5;

  logic [COARSE_W-1:0] r_coarse;
  logic [AW:0]         r_wp;
  logic [AW:0]         r_rp;
  logic [WW-1:0]       r_mem [DEPTH];
  logic [7:0]          r_ovf;

  logic                w_empty;
  logic                w_full;
  logic                w_do_rd;
  logic                w_wr_req;
  logic                w_do_wr;
  logic                w_drop;
  logic [WW-1:0]       w_word;

  // Free-running coarse time base, restarts at zero out of reset
  always_ff @(posedge i_clk300) begin
    if (i_rst) r_coarse <= '0;
    else       r_coarse <= r_coarse + 1'b1;
  end

`ifdef PIN_STAMP_ROLLOVER_EN
  logic r_pend;

  // Edge word wins over a pending rollover marker
  always_comb begin
    w_wr_req = bus.str | r_pend;
    if (bus.str) w_word = {1'b0, bus.pin_out, r_coarse, bus.ptime};
    else         w_word = {2'b10, {COARSE_W{1'b0}}, 3'b000};
  end

  // Pending flag: set when the counter wraps, cleared once a marker slot is used
  always_ff @(posedge i_clk300) begin
    if (i_rst)                 r_pend <= 1'b0;
    else if (r_coarse == '1)   r_pend <= 1'b1;
    else if (!bus.str)         r_pend <= 1'b0;
  end
`else
  // Only edge words are ever formed
  always_comb begin
    w_wr_req = bus.str;
    w_word   = {1'b0, bus.pin_out, r_coarse, bus.ptime};
  end
`endif

  // Extra wrap bit on the pointers separates full from empty
  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_do_rd = bus.rd_en & ~w_empty;
  assign w_do_wr = w_wr_req & (~w_full | w_do_rd);
  assign w_drop  = w_wr_req & w_full & ~w_do_rd;

  // Storage array; a write into the slot being popped is safe since the pop uses the old value
  always_ff @(posedge i_clk300) begin
    if (w_do_wr && !i_rst) r_mem[r_wp[AW-1:0]] <= w_word;
  end

  // Pointer update
  always_ff @(posedge i_clk300) begin
    if (i_rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_do_wr) r_wp <= r_wp + 1'b1;
      if (w_do_rd) r_rp <= r_rp + 1'b1;
    end
  end

  // Saturating count of words lost to a full FIFO
  always_ff @(posedge i_clk300) begin
    if (i_rst)                         r_ovf <= '0;
    else if (w_drop && r_ovf != 8'hFF) r_ovf <= r_ovf + 1'b1;
  end

  assign bus.dout    = w_empty ? '0 : r_mem[r_rp[AW-1:0]];
  assign bus.empty   = w_empty;
  assign bus.full    = w_full;
  assign bus.ovf_cnt = r_ovf;
endmodule

// File: tb/tb_pin_stamp.sv
// tb/tb_pin_stamp.sv - self-checking bench for pin_stamp
module tb_pin_stamp;
  localparam int CW = 12;
  localparam int DP = 16;
  localparam int WW = CW + 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pin_stamp_if #(.COARSE_W(CW)) bus ();

  pin_stamp #(.COARSE_W(CW), .DEPTH(DP)) dut (
    .i_clk300 (clk),
    .i_rst    (rst),
    .bus      (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: word queue, drop count, cycles since reset
  logic [WW-1:0] mq[$];
  int            m_ovf;
  int            m_t;
  bit            m_pend;

  typedef struct {
    bit            s;
    bit            p;
    logic [2:0]    pt;
    bit            rd;
    bit            r;
    bit            e_empty;
    bit            e_full;
    int            e_ovf;
    logic [WW-1:0] e_dout;
  } vec_t;

  vec_t tbl[9];

  function automatic logic [WW-1:0] mkw(input logic [1:0] ty, input int c, input logic [2:0] f);
    return {ty, c[CW-1:0], f};
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit s, input bit p, input logic [2:0] pt, input bit rd, input bit r);
    bit            pop;
    bit            wreq;
    bit            was_full;
    logic [WW-1:0] w;
    bus.str     = s;
    bus.pin_out = p;
    bus.ptime   = pt;
    bus.rd_en   = rd;
    rst         = r;
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_ovf  = 0;
      m_t    = 0;
      m_pend = 0;
    end else begin
      pop      = rd && (mq.size() > 0);
      was_full = (mq.size() == DP);
      wreq     = s;
      w        = mkw(p ? 2'b01 : 2'b00, m_t % (1 << CW), pt);
`ifdef PIN_STAMP_ROLLOVER_EN
      if (!s && m_pend) begin
        wreq = 1;
        w    = mkw(2'b10, 0, 3'd0);
      end
      if (!s) m_pend = 0;
      if ((m_t + 1) % (1 << CW) == 0) m_pend = 1;
`endif
      if (pop) void'(mq.pop_front());
      if (wreq) begin
        if (was_full && !pop) begin
          if (m_ovf < 255) m_ovf++;
        end else begin
          mq.push_back(w);
        end
      end
      m_t++;
    end
    #1;
    cmp("empty", 32'(bus.empty), 32'(mq.size() == 0));
    cmp("full", 32'(bus.full), 32'(mq.size() == DP));
    cmp("ovf_cnt", 32'(bus.ovf_cnt), 32'(m_ovf));
    if (mq.size() > 0) cmp("dout", 32'(bus.dout), 32'(mq[0]));
    if (r) cmp("dout_rst", 32'(bus.dout), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 3'd0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.str = 0; bus.pin_out = 0; bus.ptime = 3'd0; bus.rd_en = 0;
    m_ovf = 0; m_t = 0; m_pend = 0;

    // Directed table: reset, first-cycle stamp, FWFT, empty pop, one-word read/write overlap
    tbl[0] = '{0, 0, 3'd0, 0, 1, 1, 0, 0, '0};
    tbl[1] = '{1, 1, 3'd5, 0, 0, 0, 0, 0, mkw(2'b01, 0, 3'd5)};
    tbl[2] = '{1, 0, 3'd2, 0, 0, 0, 0, 0, mkw(2'b01, 0, 3'd5)};
    tbl[3] = '{0, 0, 3'd0, 1, 0, 0, 0, 0, mkw(2'b00, 1, 3'd2)};
    tbl[4] = '{0, 0, 3'd0, 1, 0, 1, 0, 0, '0};
    tbl[5] = '{0, 0, 3'd0, 1, 0, 1, 0, 0, '0};
    tbl[6] = '{1, 1, 3'd7, 1, 0, 0, 0, 0, mkw(2'b01, 5, 3'd7)};
    tbl[7] = '{1, 0, 3'd0, 1, 0, 0, 0, 0, mkw(2'b00, 6, 3'd0)};
    tbl[8] = '{0, 0, 3'd0, 1, 0, 1, 0, 0, '0};
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].s, tbl[i].p, tbl[i].pt, tbl[i].rd, tbl[i].r);
      cmp($sformatf("tbl%0d_empty", i), 32'(bus.empty), 32'(tbl[i].e_empty));
      cmp($sformatf("tbl%0d_full", i), 32'(bus.full), 32'(tbl[i].e_full));
      cmp($sformatf("tbl%0d_ovf", i), 32'(bus.ovf_cnt), 32'(tbl[i].e_ovf));
      if (!tbl[i].e_empty || tbl[i].r)
        cmp($sformatf("tbl%0d_dout", i), 32'(bus.dout), 32'(tbl[i].e_dout));
    end

    // Stamp at cycle 10 after reset, popped in the next cycle
    step(0, 0, 3'd0, 0, 1);
    idle(10);
    step(1, 1, 3'd5, 0, 0);
    cmp("c10_empty", 32'(bus.empty), 32'd0);
    cmp("c10_dout", 32'(bus.dout), 32'(mkw(2'b01, 10, 3'd5)));
    step(0, 0, 3'd0, 1, 0);
    cmp("c10_popped", 32'(bus.empty), 32'd1);

    // Fill to full, one drop, drain in order
    step(0, 0, 3'd0, 0, 1);
    for (int i = 0; i < 16; i++) step(1, i[0], 3'(i), 0, 0);
    cmp("fill_full", 32'(bus.full), 32'd1);
    step(1, 1, 3'd1, 0, 0);
    cmp("fill_ovf", 32'(bus.ovf_cnt), 32'd1);
    for (int i = 0; i < 16; i++) begin
      cmp($sformatf("drain%0d", i), 32'(bus.dout), 32'(mkw(i[0] ? 2'b01 : 2'b00, i, 3'(i))));
      step(0, 0, 3'd0, 1, 0);
    end
    cmp("drain_empty", 32'(bus.empty), 32'd1);

    // Full with simultaneous write and pop
    step(0, 0, 3'd0, 0, 1);
    for (int i = 0; i < 16; i++) step(1, 1, 3'd3, 0, 0);
    step(1, 0, 3'd6, 1, 0);
    cmp("wr_rd_full", 32'(bus.full), 32'd1);
    cmp("wr_rd_ovf", 32'(bus.ovf_cnt), 32'd0);
    for (int i = 0; i < 15; i++) step(0, 0, 3'd0, 1, 0);
    cmp("newest_last", 32'(bus.dout), 32'(mkw(2'b00, 16, 3'd6)));
    step(0, 0, 3'd0, 1, 0);
    cmp("newest_empty", 32'(bus.empty), 32'd1);

    // Reset with stored words, stamp in the first cycle after reset
    step(0, 0, 3'd0, 0, 1);
    for (int i = 0; i < 16; i++) step(1, 1, 3'd0, 0, 0);
    step(1, 1, 3'd0, 0, 0);
    step(1, 1, 3'd4, 0, 1);
    cmp("rst_empty", 32'(bus.empty), 32'd1);
    cmp("rst_ovf", 32'(bus.ovf_cnt), 32'd0);
    step(1, 0, 3'd1, 0, 0);
    cmp("post_rst_coarse", 32'(bus.dout), 32'(mkw(2'b00, 0, 3'd1)));

    // Drop counter saturation
    step(0, 0, 3'd0, 0, 1);
    for (int i = 0; i < 316; i++) step(1, 1, 3'd2, 0, 0);
    cmp("ovf_sat", 32'(bus.ovf_cnt), 32'd255);

    // Random traffic with varying read pressure, resets only early on
    step(0, 0, 3'd0, 0, 1);
    for (int i = 0; i < 6500; i++) begin
      int rdp;
      rdp = ((i / 250) % 3 == 0) ? 10 : (((i / 250) % 3 == 1) ? 50 : 90);
      step($urandom_range(0, 99) < 55, 1'($urandom), 3'($urandom),
           $urandom_range(0, 99) < rdp,
           (i < 2000) && ($urandom_range(0, 299) == 0));
`ifndef PIN_STAMP_ROLLOVER_EN
      if (!bus.empty) cmp("no_marker", 32'(bus.dout[WW-1 -: 2] == 2'b10), 32'd0);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
